// File: rtl/hwpe_cfg_slave_regfile_if.sv
// Peripheral configuration bus: request channel from the crossbar, registered response back.
`default_nettype none

interface hwpe_cfg_slave_regfile_if #(
  parameter int ID_WIDTH = 5
);
  logic                cfg_req;
  logic [31:0]         cfg_add;
  logic                cfg_wen;
  logic [31:0]         cfg_wdata;
  logic [3:0]          cfg_be;
  logic [ID_WIDTH-1:0] cfg_id;
  logic                cfg_gnt;
  logic [31:0]         cfg_r_rdata;
  logic                cfg_r_opc;
  logic [ID_WIDTH-1:0] cfg_r_id;
  logic                cfg_r_valid;

  modport master (
    output cfg_req, cfg_add, cfg_wen, cfg_wdata, cfg_be, cfg_id,
    input  cfg_gnt, cfg_r_rdata, cfg_r_opc, cfg_r_id, cfg_r_valid
  );

  modport slave (
    input  cfg_req, cfg_add, cfg_wen, cfg_wdata, cfg_be, cfg_id,
    output cfg_gnt, cfg_r_rdata, cfg_r_opc, cfg_r_id, cfg_r_valid
  );
endinterface

`default_nettype wire

// File: rtl/hwpe_cfg_slave_regfile.sv
// HWPE configuration slave: job register file, start/done job FSM and cycle counter,
// answering every peripheral request with a fixed one-cycle registered response.
`default_nettype none

module hwpe_cfg_slave_regfile #(
  parameter int NB_REGS    = 8,
  parameter int ID_WIDTH   = 5,
  parameter int ADDR_WIDTH = 8
) (
  input  wire                    clk,
  input  wire                    rst,
  hwpe_cfg_slave_regfile_if.slave bus,
  output logic                   job_start_o,
  input  wire                    job_done_i,
  output logic                   busy_o,
  output logic                   evt_o,
  output logic [32*NB_REGS-1:0]  reg_file_o
);

  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [WW-1:0] c_OFS_TRIG   = WW'(0);
  localparam logic [WW-1:0] c_OFS_STATUS = WW'(1);
  localparam logic [WW-1:0] c_OFS_CLEAR  = WW'(2);
  localparam logic [WW-1:0] c_OFS_CYCLES = WW'(3);
  localparam logic [WW-1:0] c_OFS_GEN    = WW'(16);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_RUN = 2'd2} state_t;

  state_t              r_state, w_state_n;
  logic [31:0]         r_regs [NB_REGS];
  logic [31:0]         r_cycles;
  logic                r_done;
  logic                r_evt;
  logic                r_valid;
  logic                r_opc;
  logic [31:0]         r_rdata;
  logic [ID_WIDTH-1:0] r_id;

  logic [WW-1:0]      w_word;
  logic               w_wr, w_rd, w_busy;
  logic               w_trig_ok, w_clr, w_evt_n;
  logic [NB_REGS-1:0] w_gen_hit;
  logic [31:0]        w_rdata;
  logic               w_opc;
  logic               w_unused_add;

  assign w_word       = bus.cfg_add[ADDR_WIDTH-1:2];
  assign w_unused_add = ^{bus.cfg_add[31:ADDR_WIDTH], bus.cfg_add[1:0]};
  assign w_wr         = bus.cfg_req & ~bus.cfg_wen;
  assign w_rd         = bus.cfg_req &  bus.cfg_wen;
  assign w_busy       = (r_state != S_IDLE);
  assign w_trig_ok    = w_wr && (w_word == c_OFS_TRIG) && !w_busy;
  assign w_clr        = w_wr && (w_word == c_OFS_CLEAR);

  always_comb begin
    for (int i = 0; i < NB_REGS; i++) begin
      w_gen_hit[i] = (w_word == c_OFS_GEN + WW'(i));
    end
  end

  // Decode and read mux; evaluated on the request cycle so reads see pre-write state.
  always_comb begin
    w_rdata = 32'h0;
    w_opc   = 1'b0;
    if (w_word == c_OFS_TRIG) begin
      w_opc = w_wr & w_busy;
    end else if (w_word == c_OFS_STATUS) begin
      w_opc = w_wr;
      if (w_rd) w_rdata = {30'b0, r_done, w_busy};
    end else if (w_word == c_OFS_CLEAR) begin
      w_opc = 1'b0;
    end else if (w_word == c_OFS_CYCLES) begin
      w_opc = w_wr;
      if (w_rd) w_rdata = r_cycles;
    end else if (|w_gen_hit) begin
      w_opc = w_wr & w_busy;
      for (int i = 0; i < NB_REGS; i++) begin
        if (w_gen_hit[i] && w_rd) w_rdata = r_regs[i];
      end
    end else begin
      w_opc = bus.cfg_req;
    end
  end

  always_comb begin
    w_state_n = r_state;
    if (w_clr) begin
      w_state_n = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_trig_ok) w_state_n = S_START;
        S_START: w_state_n = S_RUN;
        S_RUN:   if (job_done_i) w_state_n = S_IDLE;
        default: w_state_n = S_IDLE;
      endcase
    end
    w_evt_n = (r_state == S_RUN) && job_done_i && !w_clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NB_REGS; i++) r_regs[i] <= 32'h0;
      r_cycles <= 32'h0;
      r_done   <= 1'b0;
      r_evt    <= 1'b0;
      r_valid  <= 1'b0;
      r_opc    <= 1'b0;
      r_rdata  <= 32'h0;
      r_id     <= '0;
    end else begin
      r_valid <= bus.cfg_req;
      r_opc   <= w_opc;
      r_rdata <= w_rdata;
      r_id    <= bus.cfg_id;
      r_evt   <= w_evt_n;
      if (w_clr) begin
        for (int i = 0; i < NB_REGS; i++) r_regs[i] <= 32'h0;
        r_cycles <= 32'h0;
        r_done   <= 1'b0;
      end else begin
        for (int i = 0; i < NB_REGS; i++) begin
          for (int b = 0; b < 4; b++) begin
            if (w_wr && w_gen_hit[i] && !w_busy && bus.cfg_be[b])
              r_regs[i][8*b +: 8] <= bus.cfg_wdata[8*b +: 8];
          end
        end
        if (r_state == S_START)
          r_cycles <= 32'h0;
        else if (r_state == S_RUN && r_cycles != 32'hFFFF_FFFF)
          r_cycles <= r_cycles + 32'h1;
        if (w_trig_ok) r_done <= 1'b0;
        else if (w_evt_n) r_done <= 1'b1;
      end
    end
  end

  assign bus.cfg_gnt     = bus.cfg_req;
  assign bus.cfg_r_valid = r_valid;
  assign bus.cfg_r_opc   = r_opc;
  assign bus.cfg_r_rdata = r_rdata;
  assign bus.cfg_r_id    = r_id;
  assign job_start_o     = (r_state == S_START);
  assign busy_o          = w_busy;
  assign evt_o           = r_evt;

  generate
    for (genvar g = 0; g < NB_REGS; g++) begin : g_flat
      assign reg_file_o[32*g +: 32] = r_regs[g];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_hwpe_cfg_slave_regfile.sv
// Directed bench for hwpe_cfg_slave_regfile: register vector table plus job-FSM sequences.
`default_nettype none

module tb_hwpe_cfg_slave_regfile;

  localparam int NB_REGS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic job_done_i = 1'b0;
  logic job_start_o, busy_o, evt_o;
  logic [32*NB_REGS-1:0] reg_file_o;

  int n_chk = 0;
  int n_err = 0;

  hwpe_cfg_slave_regfile_if #(.ID_WIDTH(5)) bus ();

  hwpe_cfg_slave_regfile #(.NB_REGS(NB_REGS), .ID_WIDTH(5), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .job_start_o(job_start_o), .job_done_i(job_done_i),
    .busy_o(busy_o), .evt_o(evt_o), .reg_file_o(reg_file_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [31:0] add;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [4:0]  id;
    logic [31:0] erd;
    logic        eopc;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Presents one request (or an idle cycle) at a negedge, then checks its response one cycle later.
  task automatic drive(input logic req, input logic wen, input logic [31:0] add,
                       input logic [31:0] wdata, input logic [3:0] be, input logic [4:0] id,
                       input logic [31:0] erd, input logic eopc, input string nm);
    bus.cfg_req = req; bus.cfg_wen = wen; bus.cfg_add = add;
    bus.cfg_wdata = wdata; bus.cfg_be = be; bus.cfg_id = id;
    #1;
    if (req) chk({nm, ".gnt"}, {31'b0, bus.cfg_gnt}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cfg_req = 1'b0;
    chk({nm, ".valid"}, {31'b0, bus.cfg_r_valid}, {31'b0, req});
    if (req) begin
      chk({nm, ".id"},    {27'b0, bus.cfg_r_id}, {27'b0, id});
      chk({nm, ".rdata"}, bus.cfg_r_rdata, erd);
      chk({nm, ".opc"},   {31'b0, bus.cfg_r_opc}, {31'b0, eopc});
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 5'd0, 32'h0, 1'b0, "idle");
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".gnt"},   {31'b0, bus.cfg_gnt}, 32'd0);
    chk({nm, ".valid"}, {31'b0, bus.cfg_r_valid}, 32'd0);
    chk({nm, ".rdata"}, bus.cfg_r_rdata, 32'd0);
    chk({nm, ".opc"},   {31'b0, bus.cfg_r_opc}, 32'd0);
    chk({nm, ".rid"},   {27'b0, bus.cfg_r_id}, 32'd0);
    chk({nm, ".start"}, {31'b0, job_start_o}, 32'd0);
    chk({nm, ".busy"},  {31'b0, busy_o}, 32'd0);
    chk({nm, ".evt"},   {31'b0, evt_o}, 32'd0);
    chk({nm, ".regs"},  {31'b0, |reg_file_o}, 32'd0);
  endtask

  vec_t vt [16];

  initial begin
    vt[0]  = '{1'b0, 32'h044, 32'hA5A5A5A5, 4'b0101, 5'd1,  32'h0,        1'b0};
    vt[1]  = '{1'b1, 32'h044, 32'h0,        4'hF,    5'd2,  32'h00A500A5, 1'b0};
    vt[2]  = '{1'b0, 32'h040, 32'h12345678, 4'hF,    5'd3,  32'h0,        1'b0};
    vt[3]  = '{1'b0, 32'h040, 32'hFFFFFFFF, 4'h0,    5'd4,  32'h0,        1'b0};
    vt[4]  = '{1'b1, 32'h040, 32'h0,        4'hF,    5'd5,  32'h12345678, 1'b0};
    vt[5]  = '{1'b0, 32'h05C, 32'hDEADBEEF, 4'b1000, 5'd6,  32'h0,        1'b0};
    vt[6]  = '{1'b1, 32'h05C, 32'h0,        4'hF,    5'd7,  32'hDE000000, 1'b0};
    vt[7]  = '{1'b1, 32'h03C, 32'h0,        4'hF,    5'd8,  32'h0,        1'b1};
    vt[8]  = '{1'b0, 32'h0FC, 32'h11111111, 4'hF,    5'd9,  32'h0,        1'b1};
    vt[9]  = '{1'b1, 32'h060, 32'h0,        4'hF,    5'd10, 32'h0,        1'b1};
    vt[10] = '{1'b1, 32'h000, 32'h0,        4'hF,    5'd11, 32'h0,        1'b0};
    vt[11] = '{1'b1, 32'h004, 32'h0,        4'hF,    5'd12, 32'h0,        1'b0};
    vt[12] = '{1'b0, 32'h004, 32'h3,        4'hF,    5'd13, 32'h0,        1'b1};
    vt[13] = '{1'b0, 32'h00C, 32'h5,        4'hF,    5'd14, 32'h0,        1'b1};
    vt[14] = '{1'b1, 32'h00C, 32'h0,        4'hF,    5'd15, 32'h0,        1'b0};
    vt[15] = '{1'b1, 32'h344, 32'h0,        4'hF,    5'd31, 32'h00A500A5, 1'b0};

    bus.cfg_req = 1'b0; bus.cfg_wen = 1'b1; bus.cfg_add = 32'h0;
    bus.cfg_wdata = 32'h0; bus.cfg_be = 4'h0; bus.cfg_id = 5'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vt[i].wen, vt[i].add, vt[i].wdata, vt[i].be, vt[i].id,
            vt[i].erd, vt[i].eopc, $sformatf("vec%0d", i));
    end
    chk("regfile.r1", reg_file_o[63:32],   32'h00A500A5);
    chk("regfile.r0", reg_file_o[31:0],    32'h12345678);
    chk("regfile.r7", reg_file_o[255:224], 32'hDE000000);

    // Back-to-back reads: responses on consecutive cycles.
    bus.cfg_req = 1'b1; bus.cfg_wen = 1'b1; bus.cfg_add = 32'h44; bus.cfg_id = 5'd3;
    @(posedge clk); @(negedge clk);
    bus.cfg_id = 5'd4; bus.cfg_add = 32'h40;
    chk("b2b.v3",  {31'b0, bus.cfg_r_valid}, 32'd1);
    chk("b2b.id3", {27'b0, bus.cfg_r_id}, 32'd3);
    chk("b2b.d3",  bus.cfg_r_rdata, 32'h00A500A5);
    @(posedge clk); @(negedge clk);
    bus.cfg_req = 1'b0;
    chk("b2b.v4",  {31'b0, bus.cfg_r_valid}, 32'd1);
    chk("b2b.id4", {27'b0, bus.cfg_r_id}, 32'd4);
    chk("b2b.d4",  bus.cfg_r_rdata, 32'h12345678);
    @(posedge clk); @(negedge clk);
    chk("b2b.v_end", {31'b0, bus.cfg_r_valid}, 32'd0);

    // Job run: trigger at cycle t (k=0), done at t+10.
    for (int k = 0; k < 15; k++) begin
      job_done_i = (k == 10);
      case (k)
        0:  drive(1'b1, 1'b0, 32'h00, 32'h1, 4'hF, 5'd20, 32'h0, 1'b0, "run.trig");
        2:  drive(1'b1, 1'b1, 32'h04, 32'h0, 4'hF, 5'd21, 32'h1, 1'b0, "run.status_busy");
        3:  drive(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 5'd22, 32'h0, 1'b1, "run.wr_busy");
        4:  drive(1'b1, 1'b0, 32'h00, 32'h1, 4'hF, 5'd23, 32'h0, 1'b1, "run.trig2");
        5:  drive(1'b1, 1'b1, 32'h40, 32'h0, 4'hF, 5'd24, 32'h12345678, 1'b0, "run.rd_r0");
        12: drive(1'b1, 1'b1, 32'h04, 32'h0, 4'hF, 5'd25, 32'h2, 1'b0, "run.status_done");
        13: drive(1'b1, 1'b1, 32'h0C, 32'h0, 4'hF, 5'd26, 32'd9, 1'b0, "run.cycles");
        default: idle();
      endcase
      chk($sformatf("run.start@%0d", k + 1), {31'b0, job_start_o}, {31'b0, (k + 1 == 1)});
      chk($sformatf("run.evt@%0d", k + 1),   {31'b0, evt_o},       {31'b0, (k + 1 == 11)});
      chk($sformatf("run.busy@%0d", k + 1),  {31'b0, busy_o},      {31'b0, (k + 1 >= 1 && k + 1 <= 10)});
    end
    job_done_i = 1'b0;

    // SOFT_CLEAR coincident with job_done_i in RUN.
    drive(1'b1, 1'b0, 32'h00, 32'h1, 4'hF, 5'd1, 32'h0, 1'b0, "sc.trig");
    repeat (3) idle();
    chk("sc.busy_run", {31'b0, busy_o}, 32'd1);
    job_done_i = 1'b1;
    drive(1'b1, 1'b0, 32'h08, 32'h1, 4'hF, 5'd2, 32'h0, 1'b0, "sc.clear");
    job_done_i = 1'b0;
    chk("sc.evt0", {31'b0, evt_o},  32'd0);
    chk("sc.busy", {31'b0, busy_o}, 32'd0);
    chk("sc.regs", {31'b0, |reg_file_o}, 32'd0);
    drive(1'b1, 1'b1, 32'h04, 32'h0, 4'hF, 5'd3, 32'h0, 1'b0, "sc.status");
    chk("sc.evt1", {31'b0, evt_o}, 32'd0);
    drive(1'b1, 1'b1, 32'h0C, 32'h0, 4'hF, 5'd4, 32'h0, 1'b0, "sc.cycles");

    // Reset mid-job with a read in flight.
    drive(1'b1, 1'b0, 32'h48, 32'hCAFEF00D, 4'hF, 5'd5, 32'h0, 1'b0, "rst.wr");
    drive(1'b1, 1'b0, 32'h00, 32'h1, 4'hF, 5'd6, 32'h0, 1'b0, "rst.trig");
    repeat (3) idle();
    chk("rst.busy_pre", {31'b0, busy_o}, 32'd1);
    bus.cfg_req = 1'b1; bus.cfg_wen = 1'b1; bus.cfg_add = 32'h48; bus.cfg_id = 5'd7;
    #2 rst = 1'b1;
    bus.cfg_req = 1'b0;
    #1 chk_all_zero("rst.now");
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("rst.novalid%0d", c), {31'b0, bus.cfg_r_valid}, 32'd0);
      chk($sformatf("rst.idle%0d", c),    {31'b0, busy_o}, 32'd0);
    end
    drive(1'b1, 1'b1, 32'h04, 32'h0, 4'hF, 5'd8, 32'h0, 1'b0, "rst.status");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/hwpe_cfg_slave_regfile.md
Name: hwpe_cfg_slave_regfile

Overview:
- Target end of the XBAR_PERIPH_BUS configuration path.
- Accepts peripheral requests routed to one HWPE wrapper and answers them.
- Holds the accelerator's job register file and a job-control FSM that sequences start/done.
- Returns read data, error opcode and ID with fixed one-cycle latency.

Parameters:
- NB_REGS, 8, number of 32-bit generic job registers at offsets 0x40 + 4*i.
- ID_WIDTH, 5, width of request/response ID.
- ADDR_WIDTH, 8, low address bits decoded; upper bits ignored.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- cfg_req  in  1  request valid.
- cfg_add  in  32  byte address.
- cfg_wen  in  1  1 = read, 0 = write.
- cfg_wdata  in  32  write data.
- cfg_be  in  4  byte enables.
- cfg_id  in  ID_WIDTH  request ID.
- cfg_gnt  out  1  grant.
- cfg_r_rdata  out  32  read data.
- cfg_r_opc  out  1  0 = OK, 1 = error.
- cfg_r_id  out  ID_WIDTH  response ID.
- cfg_r_valid  out  1  response valid.
- job_start_o  out  1  one-cycle start pulse to engine.
- job_done_i  in  1  engine completion pulse.
- busy_o  out  1  job in progress.
- evt_o  out  1  one-cycle completion event to cluster event unit.
- reg_file_o  out  32*NB_REGS  generic registers, flat, reg 0 in LSBs.

Behaviour:
- Reset values:
  - All outputs 0.
  - Registers, cycle counter and done flag 0.
  - FSM in IDLE.
- Grant:
  - cfg_gnt = cfg_req, combinational; every request accepted in the cycle presented.
- Response:
  - Registered; cfg_r_valid = 1 exactly one cycle after each granted request.
  - cfg_r_id = captured cfg_id.
  - Back-to-back requests give back-to-back responses.
- Address map (cfg_add[ADDR_WIDTH-1:0], word aligned; add[1:0] ignored):
  - 0x00 TRIGGER: write only; read returns 0, OK.
  - 0x04 STATUS: read {30'b0, done, busy}; write = error.
  - 0x08 SOFT_CLEAR: write only.
  - 0x0C CYCLES: read-only cycle counter; write = error.
  - 0x40..0x40+4*(NB_REGS-1): generic RW registers.
- Any other offset: r_opc = 1, r_rdata = 0, no state change.
- Generic register writes:
  - Per-byte update by cfg_be.
  - be = 0 completes OK with no change.
  - Write while busy_o = 1: r_opc = 1, register unchanged. Reads always allowed.
- Read data is sampled in the request cycle, so a read sees pre-write values of any write in the same cycle.
- FSM states IDLE, START, RUN:
  - IDLE: TRIGGER write → START, OK response, done flag cleared. TRIGGER write in START/RUN: r_opc = 1, ignored.
  - START: job_start_o = 1 for exactly one cycle; CYCLES reset to 0; next state RUN. job_done_i ignored.
  - RUN: CYCLES increments each cycle, saturating at 0xFFFFFFFF. On job_done_i → IDLE, done flag = 1, evt_o = 1 for one cycle.
  - busy_o = 1 in START and RUN.
  - job_done_i in IDLE is ignored.
- SOFT_CLEAR write:
  - Response OK.
  - Next cycle: FSM → IDLE; registers, CYCLES and done flag → 0.
  - Overrides a same-cycle job_done_i: no evt_o, done stays 0.
  - Valid in any state.
- Reset asserted mid-job:
  - All state returns to reset values immediately.
  - A pending response is dropped; no r_valid after release.
- done flag: sticky until next TRIGGER or SOFT_CLEAR.

Test Plan:
- Write 0xA5A5A5A5, be = 4'b0101, to 0x44, then read 0x44 → reads 0x00A500A5, r_opc = 0; r_valid and r_id match request at +1 cycle; reg_file_o[63:32] = 0x00A500A5.
- Write TRIGGER at cycle t, assert job_done_i at t+10:
  - job_start_o high at t+1 only.
  - STATUS = 0x1 during run; then 0x2.
  - CYCLES = 9.
  - evt_o high one cycle at t+11.
- During RUN: write 0x40 → r_opc = 1, value unchanged; second TRIGGER → r_opc = 1, no extra job_start_o.
- Read 0x3C and write 0xFC → r_opc = 1, r_rdata = 0; back-to-back reads with IDs 3, 4 → responses on consecutive cycles with IDs 3, 4.
- SOFT_CLEAR coincident with job_done_i in RUN → no evt_o; STATUS = 0; all reg_file_o = 0.
- Assert rst while in RUN with a read pending → all outputs 0 immediately; no r_valid after release; FSM IDLE.
